fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 Parameter NOP_INST, default 32'h0000_0013 (addi x0,x0,0), is the value driven on InstF when no valid instruction is held.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 imem_req_valid  output  1  fetch request valid.
REQ-006 imem_req_ready  input  1  instruction memory accepts the request.
REQ-007 imem_addr  output  32  fetch address; word-aligned.
REQ-008 imem_rsp_valid  input  1  response data valid; responses return in request order, at least 1 cycle after acceptance.
REQ-009 imem_rdata  input  32  fetched instruction word.
REQ-010 stall  input  1  downstream cannot consume this cycle.
REQ-011 PCsrc  input  1  redirect request (taken branch/jump).
REQ-012 br_target  input  32  redirect address.
REQ-013 InstF  output  32  instruction word to the decoder.
REQ-014 PCF  output  32  address of InstF.
REQ-015 inst_valid  output  1  InstF/PCF hold a real instruction.

Function
REQ-016 The block SHALL keep a 2-entry in-order instruction buffer of {inst, pc} pairs; at most 2 requests SHALL be outstanding, and (outstanding + buffer occupancy) SHALL never exceed 2.
REQ-017 A request SHALL be accepted on the cycle where imem_req_valid && imem_req_ready; imem_addr SHALL then advance by 4, wrapping 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-018 imem_req_valid SHALL be 1 only in state RUN with available credit, and imem_addr SHALL stay stable while imem_req_valid=1 and imem_req_ready=0.
REQ-019 inst_valid SHALL equal "buffer not empty"; InstF/PCF SHALL show the head entry, else NOP_INST and the last PCF value.
REQ-020 The head SHALL be popped on a cycle where inst_valid && !stall && !PCsrc; a response SHALL be pushed the same cycle it arrives, giving 1-cycle response-to-inst_valid latency.
REQ-021 FSM states: BOOT, RUN, FLUSH; BOOT lasts exactly one cycle after reset release, then goes to RUN with no request issued in BOOT.
REQ-022 On PCsrc=1 in any state, the buffer SHALL be cleared at that edge, the next fetch address SHALL be {br_target[31:2],2'b00}, and inst_valid SHALL be 0 on the following cycle.
REQ-023 On PCsrc=1, drop_cnt SHALL load the number of requests still outstanding after that edge, excluding any response arriving in the same cycle; that response SHALL be discarded.
REQ-024 If drop_cnt loads nonzero, the FSM SHALL enter FLUSH; otherwise it SHALL enter or stay in RUN (BOOT included).
REQ-025 In FLUSH, each arriving response SHALL decrement drop_cnt and be discarded; no request SHALL issue; at drop_cnt=0 the FSM SHALL go to RUN.
REQ-026 PCsrc in FLUSH SHALL update only the fetch address; drop_cnt SHALL just decrement for any response that cycle.
REQ-027 PCsrc SHALL take priority over stall; a request handshaking in the same cycle as PCsrc SHALL count as outstanding and be dropped.
REQ-028 A response arriving while the buffer is full SHALL not occur, by construction of REQ-016.

Reset
REQ-029 While rst=0: state=BOOT, imem_addr=RESET_PC, imem_req_valid=0, buffer empty, inst_valid=0, InstF=NOP_INST, PCF=RESET_PC, drop_cnt=0, outstanding=0.
REQ-030 Reset asserted mid-operation SHALL abandon all outstanding requests; responses arriving after release with no outstanding request SHALL be ignored.

Verification
REQ-031 Reset release, imem_req_ready=1, 1-cycle memory -> requests at 0x0,0x4,0x8 on consecutive cycles after BOOT; inst_valid=1 with PCF=0x0 two cycles after the first request.
REQ-032 stall=1 for 4 cycles with buffer filling -> imem_req_valid drops at occupancy 2; InstF held at PCF=0x8; fetch resumes from 0x10 after stall falls.
REQ-033 PCsrc=1, br_target=0x100, 2 outstanding -> FLUSH; both responses dropped; next request 0x100; first inst_valid has PCF=0x100.
REQ-034 PCsrc=1, br_target=0x203 -> imem_addr=0x200.
REQ-035 Fetch at 0xFFFF_FFFC accepted -> next imem_addr=0x0000_0000.
REQ-036 rst=0 with 1 outstanding, stray response after release -> discarded; inst_valid stays 0 until a response to RESET_PC.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response channel between fetch_unit and imem.
// master: fetch side (drives request); slave: memory side (drives ready/response).
interface fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req_valid,
        output imem_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: in-order requests to imem, 2-entry {inst,pc} buffer, redirect flush.
// Ports: clk, rst (async active-low), imem (request/response channel), stall, PCsrc,
// br_target (redirect), InstF/PCF/inst_valid (head of buffer to decode).
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master imem,
    input  logic         stall,
    input  logic         PCsrc,
    input  logic [31:0]  br_target,
    output logic [31:0]  InstF,
    output logic [31:0]  PCF,
    output logic         inst_valid
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] rpc_q, rpc_d;
    logic [31:0] pcf_q;
    logic [1:0]  out_q, out_d;
    logic [1:0]  drop_q, drop_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] inst0_q, inst0_d, inst1_q, inst1_d;
    logic [31:0] pc0_q, pc0_d, pc1_q, pc1_d;

    logic        fire, take, pop, push;
    logic [2:0]  used;
    logic [1:0]  level;
    logic [31:0] target;
    logic        unused_br;

    assign target    = {br_target[31:2], 2'b00};
    assign unused_br = ^br_target[1:0];

    assign inst_valid = (cnt_q != 2'd0);
    assign InstF      = inst_valid ? inst0_q : NOP_INST;
    assign PCF        = inst_valid ? pc0_q : pcf_q;

    assign pop  = inst_valid && !stall && !PCsrc;
    // Stray responses with nothing outstanding are ignored.
    assign take = imem.imem_rsp_valid && (out_q != 2'd0);
    assign push = take && (state_q == RUN) && !PCsrc;

    // Credit counts the slot freed by a pop this cycle so a non-stalled
    // stream issues one request per cycle.
    assign used = {1'b0, out_q} + {1'b0, cnt_q} - {2'b00, pop};

    assign imem.imem_req_valid = (state_q == RUN) && (used < 3'd2);
    assign imem.imem_addr      = addr_q;
    assign fire = imem.imem_req_valid && imem.imem_req_ready;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        drop_d  = drop_q;
        out_d   = out_q + {1'b0, fire} - {1'b0, take};
        if (fire) begin
            addr_d = addr_q + 32'd4;
        end
        unique case (state_q)
            BOOT:  state_d = RUN;
            RUN:   state_d = RUN;
            FLUSH: begin
                drop_d = drop_q - {1'b0, take};
                if (drop_q - {1'b0, take} == 2'd0) begin
                    state_d = RUN;
                end
            end
            default: state_d = BOOT;
        endcase
        // Every request still in flight after a redirect is stale.
        if (PCsrc) begin
            addr_d  = target;
            drop_d  = out_d;
            state_d = (out_d != 2'd0) ? FLUSH : RUN;
        end
    end

    // Non-dropped outstanding requests are always contiguous from rpc_q,
    // so the pc of each kept response is tracked without a pc queue.
    always_comb begin
        cnt_d   = cnt_q;
        inst0_d = inst0_q;
        inst1_d = inst1_q;
        pc0_d   = pc0_q;
        pc1_d   = pc1_q;
        rpc_d   = rpc_q;
        level   = cnt_q - {1'b0, pop};
        if (PCsrc) begin
            cnt_d = 2'd0;
            rpc_d = target;
        end else begin
            if (pop) begin
                inst0_d = inst1_q;
                pc0_d   = pc1_q;
            end
            if (push) begin
                if (level == 2'd0) begin
                    inst0_d = imem.imem_rdata;
                    pc0_d   = rpc_q;
                end else begin
                    inst1_d = imem.imem_rdata;
                    pc1_d   = rpc_q;
                end
                rpc_d = rpc_q + 32'd4;
            end
            cnt_d = level + {1'b0, push};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= BOOT;
            addr_q  <= RESET_PC;
            rpc_q   <= RESET_PC;
            pcf_q   <= RESET_PC;
            out_q   <= 2'd0;
            drop_q  <= 2'd0;
            cnt_q   <= 2'd0;
            inst0_q <= NOP_INST;
            inst1_q <= NOP_INST;
            pc0_q   <= RESET_PC;
            pc1_q   <= RESET_PC;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rpc_q   <= rpc_d;
            pcf_q   <= PCF;
            out_q   <= out_d;
            drop_q  <= drop_d;
            cnt_q   <= cnt_d;
            inst0_q <= inst0_d;
            inst1_q <= inst1_d;
            pc0_q   <= pc0_d;
            pc1_q   <= pc1_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        PCsrc;
    logic [31:0] br_target;
    logic [31:0] InstF;
    logic [31:0] PCF;
    logic        inst_valid;

    fetch_unit_if ifc ();

    fetch_unit dut (
        .clk       (clk),
        .rst       (rst),
        .imem      (ifc),
        .stall     (stall),
        .PCsrc     (PCsrc),
        .br_target (br_target),
        .InstF     (InstF),
        .PCF       (PCF),
        .inst_valid(inst_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'hC0DE_0001;
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

    bit          m_boot;
    logic [31:0] m_pc;
    logic [31:0] m_last;
    int          m_drop;
    logic [31:0] m_pend[$];
    ent_t        m_buf[$];

    task automatic model_reset();
        m_boot = 1'b1;
        m_pc   = RESET_PC;
        m_last = RESET_PC;
        m_drop = 0;
        m_pend.delete();
        m_buf.delete();
    endtask

    initial model_reset();

    always @(negedge clk) begin : cmp
        bit          pop, rv, iv, fire;
        logic [31:0] e_inst, e_pcf, a;
        ent_t        e;
        if (!rst) model_reset();
        iv     = (m_buf.size() > 0);
        pop    = iv && !stall && !PCsrc;
        rv     = rst && !m_boot && (m_drop == 0) &&
                 ((m_pend.size() + m_buf.size() - int'(pop)) < 2);
        e_inst = iv ? m_buf[0].inst : NOP;
        e_pcf  = iv ? m_buf[0].pc : m_last;
        chk("req_valid", 32'(ifc.imem_req_valid), 32'(rv));
        chk("imem_addr", ifc.imem_addr, m_pc);
        chk("inst_valid", 32'(inst_valid), 32'(iv));
        chk("InstF", InstF, e_inst);
        chk("PCF", PCF, e_pcf);
        if (rst) begin
            fire   = rv && ifc.imem_req_ready;
            m_last = e_pcf;
            if (pop) void'(m_buf.pop_front());
            if (ifc.imem_rsp_valid && m_pend.size() > 0) begin
                a = m_pend.pop_front();
                if (m_drop > 0) m_drop--;
                else if (!PCsrc) begin
                    e.inst = ifc.imem_rdata;
                    e.pc   = a;
                    m_buf.push_back(e);
                end
            end
            if (fire) m_pend.push_back(m_pc);
            if (PCsrc) begin
                m_buf.delete();
                m_drop = m_pend.size();
                m_pc   = {br_target[31:2], 2'b00};
            end else if (fire) begin
                m_pc = m_pc + 32'd4;
            end
            m_boot = 1'b0;
        end
    end

    // ---------------- memory + stepping ----------------
    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t mq[$];
    bit    drove_real = 1'b0;
    int    cyc = 0;
    int    lat_min = 1, lat_max = 1, rsp_pct = 100, stray_pct = 0;

    task automatic step();
        mreq_t r;
        @(negedge clk);
        #1;
        if (!rst) mq.delete();
        else begin
            if (ifc.imem_rsp_valid && drove_real) mq.delete(0);
            if (ifc.imem_req_valid && ifc.imem_req_ready) begin
                r.addr = ifc.imem_addr;
                r.due  = cyc + int'($urandom_range(lat_max, lat_min));
                mq.push_back(r);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        drove_real = 1'b0;
        if (mq.size() > 0 && mq[0].due <= cyc &&
            int'($urandom % 100) < rsp_pct) begin
            ifc.imem_rsp_valid = 1'b1;
            ifc.imem_rdata     = memf(mq[0].addr);
            drove_real         = 1'b1;
        end else if (mq.size() == 0 && int'($urandom % 100) < stray_pct) begin
            ifc.imem_rsp_valid = 1'b1;
            ifc.imem_rdata     = $urandom;
        end else begin
            ifc.imem_rsp_valid = 1'b0;
            ifc.imem_rdata     = $urandom;
        end
    endtask

    task automatic do_reset();
        rst   = 1'b0;
        PCsrc = 1'b0;
        stall = 1'b0;
        repeat (2) step();
        rst = 1'b1;
    endtask

    task automatic wait_rv(input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            if (ifc.imem_req_valid) begin
                ok = 1'b1;
                break;
            end
            step();
            #1;
        end
    endtask

    task automatic wait_iv(input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            if (inst_valid) begin
                ok = 1'b1;
                break;
            end
            step();
            #1;
        end
    endtask

    task automatic rand_in();
        stall = (($urandom % 100) < 30);
        PCsrc = (($urandom % 100) < 6);
        if (($urandom % 4) == 0) br_target = 32'hFFFF_FFF0 + ($urandom % 16);
        else br_target = $urandom % 1024;
        ifc.imem_req_ready = (($urandom % 100) < 75);
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim
        bit ok;
        int hold;
        rst = 1'b0;
        stall = 1'b0;
        PCsrc = 1'b0;
        br_target = 32'h0;
        ifc.imem_req_ready = 1'b0;
        ifc.imem_rsp_valid = 1'b0;
        ifc.imem_rdata = 32'h0;
        repeat (3) step();
        #1;
        chk("rst_req_valid", 32'(ifc.imem_req_valid), 32'd0);
        chk("rst_addr", ifc.imem_addr, RESET_PC);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_InstF", InstF, NOP);
        chk("rst_PCF", PCF, RESET_PC);

        // Streaming, 1-cycle memory, then a 4-cycle stall.
        ifc.imem_req_ready = 1'b1;
        rst = 1'b1;
        #1 chk("boot_no_req", 32'(ifc.imem_req_valid), 32'd0);
        step(); #1;
        chk("s_req0_valid", 32'(ifc.imem_req_valid), 32'd1);
        chk("s_req0_addr", ifc.imem_addr, 32'h0);
        step(); #1;
        chk("s_req1_addr", ifc.imem_addr, 32'h4);
        chk("s_iv_early", 32'(inst_valid), 32'd0);
        step(); #1;
        chk("s_iv_first", 32'(inst_valid), 32'd1);
        chk("s_pcf_first", PCF, 32'h0);
        chk("s_inst_first", InstF, memf(32'h0));
        chk("s_req2_addr", ifc.imem_addr, 32'h8);
        step(); #1;
        chk("s_req3_addr", ifc.imem_addr, 32'hC);
        step(); stall = 1'b1; #1;
        chk("stall_no_req", 32'(ifc.imem_req_valid), 32'd0);
        chk("stall_pcf", PCF, 32'h8);
        for (int i = 0; i < 3; i++) begin
            step(); #1;
            chk("stall_hold_req", 32'(ifc.imem_req_valid), 32'd0);
            chk("stall_hold_pcf", PCF, 32'h8);
        end
        step(); stall = 1'b0; #1;
        chk("resume_valid", 32'(ifc.imem_req_valid), 32'd1);
        chk("resume_addr", ifc.imem_addr, 32'h10);

        // Redirect with two requests in flight.
        rsp_pct = 0;
        do_reset();
        step(); step(); step(); #1;
        chk("fl_credit_full", 32'(ifc.imem_req_valid), 32'd0);
        PCsrc = 1'b1;
        br_target = 32'h100;
        rsp_pct = 100;
        step(); PCsrc = 1'b0; #1;
        chk("fl_no_req", 32'(ifc.imem_req_valid), 32'd0);
        chk("fl_addr", ifc.imem_addr, 32'h100);
        chk("fl_iv_cleared", 32'(inst_valid), 32'd0);
        wait_rv(20, ok);
        chk("fl_req_timeout", 32'(ok), 32'd1);
        chk("fl_next_req", ifc.imem_addr, 32'h100);
        wait_iv(20, ok);
        chk("fl_iv_timeout", 32'(ok), 32'd1);
        chk("fl_first_pcf", PCF, 32'h100);

        // Unaligned target and address wrap.
        PCsrc = 1'b1;
        br_target = 32'h203;
        step(); PCsrc = 1'b0; #1;
        chk("align_addr", ifc.imem_addr, 32'h200);
        PCsrc = 1'b1;
        br_target = 32'hFFFF_FFFC;
        step(); PCsrc = 1'b0; #1;
        wait_rv(20, ok);
        chk("wrap_req_timeout", 32'(ok), 32'd1);
        chk("wrap_top_addr", ifc.imem_addr, 32'hFFFF_FFFC);
        step(); #1;
        chk("wrap_addr", ifc.imem_addr, 32'h0);

        // Reset with a request in flight, then stray responses.
        rsp_pct = 0;
        do_reset();
        step(); step();
        rst = 1'b0;
        stray_pct = 100;
        #1 chk("mid_rst_iv", 32'(inst_valid), 32'd0);
        step(); step();
        rst = 1'b1;
        #1 chk("stray_boot_iv", 32'(inst_valid), 32'd0);
        step();
        stray_pct = 0;
        rsp_pct = 100;
        #1 chk("stray_r1_iv", 32'(inst_valid), 32'd0);
        step(); #1;
        chk("stray_r2_iv", 32'(inst_valid), 32'd0);
        wait_iv(10, ok);
        chk("stray_iv_timeout", 32'(ok), 32'd1);
        chk("stray_pcf", PCF, RESET_PC);
        chk("stray_inst", InstF, memf(RESET_PC));

        // Randomized traffic.
        lat_min = 1;
        lat_max = 4;
        rsp_pct = 70;
        stray_pct = 10;
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            step();
            rand_in();
            if (hold > 0) begin
                hold--;
                if (hold == 0) rst = 1'b1;
            end else if (($urandom % 500) == 0) begin
                rst = 1'b0;
                hold = 2;
            end
        end
        rst = 1'b1;
        PCsrc = 1'b0;
        repeat (2) step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
